seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial pattern detector with detection counter; successor to the fixed 3-bit "010" detector.
- Pattern value, pattern length, counter width and overlap mode are all generics. Adds input qualification, counter clear and overflow reporting.
- Sits on a 1-bit serial stream (user/event line) and feeds a status/statistics block.

Parameters:
- PAT_LEN, 3, pattern length in bits (2..16)
- PATTERN, 3'b010 (PAT_LEN bits), target sequence; MSB is the oldest bit received
- COUNT_W, 10, detection counter width (1..32)
- OVERLAP, 1, 1 = overlapping detection allowed, 0 = history restarts after each match

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- x_valid  in  1  qualifies x; a bit is consumed only when 1
- x  in  1  serial data bit
- cnt_clr  in  1  synchronous clear of users_count and cnt_ovf
- y  out  1  detection flag, registered
- users_count  out  COUNT_W  number of detections
- cnt_ovf  out  1  counter overflow/saturation flag, sticky

Behaviour:
- Single clock; reset synchronous, active-high.
- Reset: hist=0, fill=0, y=0, users_count=0, cnt_ovf=0. Reset has priority over every other input, including mid-pattern; a partial match is discarded.
- State:
  - hist: PAT_LEN-bit shift register; new bit enters the LSB.
  - fill: number of valid bits in hist, 0..PAT_LEN, saturating at PAT_LEN.
- Accepted bit (x_valid=1):
  - hist_n = {hist[PAT_LEN-2:0], x}; fill_n = min(fill+1, PAT_LEN).
  - match = (fill_n == PAT_LEN) && (hist_n == PATTERN).
- Match:
  - y <= 1 on the same edge; latency is exactly 1 cycle from the completing bit.
  - users_count increments on the same edge, so y and the new count are visible together.
  - OVERLAP=0: fill <= 0 after a match, so the next detection needs PAT_LEN fresh bits.
  - OVERLAP=1: hist and fill are kept.
- No match, or x_valid=0: y <= 0.
- x_valid=0: hist, fill and users_count are all held; x is ignored.
- cnt_clr=1:
  - users_count <= 0 and cnt_ovf <= 0.
  - If a match occurs in the same cycle, the clear wins: count becomes 0 and y is still asserted.
  - hist and fill are unaffected.
- Counter width: users_count is COUNT_W bits, unsigned.
- Counter at max (2^COUNT_W-1) when a match occurs: see Optional Feature.
- cnt_ovf is sticky; it is cleared only by rst or cnt_clr.
- Output y is never X after reset, including while x_valid is low.

Optional Feature:
- Macro: SEQ_DET_SATURATE_EN
- Defined:
  - users_count saturates at 2^COUNT_W-1; further matches leave it unchanged.
  - cnt_ovf sets on the first match attempted at saturation.
  - y still pulses for every match.
- Undefined:
  - users_count wraps from 2^COUNT_W-1 to 0.
  - cnt_ovf sets on the same edge as the wrap.

Test Plan (PAT_LEN=3, PATTERN=3'b010, COUNT_W=10 unless noted):
- Reset check: rst=1 for one cycle, then sample at negedge -> y=0, users_count=0, cnt_ovf=0. Repeat mid-stream after "01" -> the next "0" alone gives no detection.
- Overlap mode, OVERLAP=1, x_valid=1, stream 0,1,0,1,0 -> y high after bit 3 and after bit 5; users_count=2.
- Non-overlap mode, OVERLAP=0, same stream 0,1,0,1,0 -> y high after bit 3 only; users_count=1.
- Qualification: stream 0,1,0 with x_valid=0 on a cycle inserted between the bits, carrying x=1 -> exactly one detection; y low during the stall cycle.
- Counter boundary, COUNT_W=2, four matches:
  - SEQ_DET_SATURATE_EN defined -> count 1,2,3,3; cnt_ovf=1 after the 4th match.
  - Macro undefined -> count 1,2,3,0; cnt_ovf=1 after the 4th match.
- Clear collision: cnt_clr=1 in the same cycle a match completes, with users_count=5 -> y=1, users_count=0, cnt_ovf=0. Next match -> users_count=1.

Source files
------------

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with detection counter (optional SEQ_DET_SATURATE_EN)
module seq_detector_param #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b010,
    parameter int                 COUNT_W = 10,
    parameter int                 OVERLAP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x_valid,
    input  logic               x,
    input  logic               cnt_clr,
    output logic               y,
    output logic [COUNT_W-1:0] users_count,
    output logic               cnt_ovf
);

    localparam int                  FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [COUNT_W-1:0]  CNT_MAX   = {COUNT_W{1'b1}};

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               y_q, y_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [PAT_LEN-1:0] hist_n;
    logic [FILL_W-1:0]  fill_n;
    logic               match;

    // Next-state: shift in qualified bits, detect, count, and apply the clear last so it wins
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        y_d    = 1'b0;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;

        hist_n = {hist_q[PAT_LEN-2:0], x};
        fill_n = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        match  = x_valid && (fill_n == FILL_FULL) && (hist_n == PATTERN);

        if (x_valid) begin
            hist_d = hist_n;
            // Non-overlapping mode forgets the matched bits so the next hit needs a full fresh pattern
            fill_d = (match && (OVERLAP == 0)) ? '0 : fill_n;
            y_d    = match;
        end

        if (match) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
`ifdef SEQ_DET_SATURATE_EN
                cnt_d = cnt_q;
`else
                cnt_d = '0;
`endif
            end else begin
                cnt_d = cnt_q + COUNT_W'(1);
            end
        end

        if (cnt_clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
    end

    // State registers with synchronous reset that discards any partial match
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign y           = y_q;
    assign users_count = cnt_q;
    assign cnt_ovf     = ovf_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - self-checking bench for seq_detector_param
module tb_seq_detector_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst     = 1'b1;
    logic x_valid = 1'b0;
    logic x       = 1'b0;
    logic cnt_clr = 1'b0;

    logic       y_ov, y_no, y_c2;
    logic [9:0] c_ov, c_no;
    logic [1:0] c_c2;
    logic       o_ov, o_no, o_c2;

    seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b010), .COUNT_W(10), .OVERLAP(1)) dut_ov (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .cnt_clr(cnt_clr),
        .y(y_ov), .users_count(c_ov), .cnt_ovf(o_ov)
    );

    seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b010), .COUNT_W(10), .OVERLAP(0)) dut_no (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .cnt_clr(cnt_clr),
        .y(y_no), .users_count(c_no), .cnt_ovf(o_no)
    );

    seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b010), .COUNT_W(2), .OVERLAP(1)) dut_c2 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .cnt_clr(cnt_clr),
        .y(y_c2), .users_count(c_c2), .cnt_ovf(o_c2)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: accepted bits kept as a text string, matched against "010"
    string hist  [3];
    int    m_cnt [3];
    bit    m_y   [3];
    bit    m_ovf [3];
    int    ovl   [3];
    int    cw    [3];
    bit    model_ok = 1'b0;

    initial begin
        ovl[0] = 1; ovl[1] = 0; ovl[2] = 1;
        cw[0]  = 10; cw[1] = 10; cw[2] = 2;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        string b;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                hist[i] = ""; m_cnt[i] = 0; m_y[i] = 0; m_ovf[i] = 0;
            end
            model_ok = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_y[i] = 0;
                if (x_valid) begin
                    b = x ? "1" : "0";
                    hist[i] = {hist[i], b};
                    if (hist[i].len() > 3)
                        hist[i] = hist[i].substr(hist[i].len() - 3, hist[i].len() - 1);
                    if (hist[i] == "010") begin
                        m_y[i] = 1;
                        if (m_cnt[i] == (1 << cw[i]) - 1) begin
                            m_ovf[i] = 1;
`ifndef SEQ_DET_SATURATE_EN
                            m_cnt[i] = 0;
`endif
                        end else begin
                            m_cnt[i]++;
                        end
                        if (ovl[i] == 0) hist[i] = "";
                    end
                end
                if (cnt_clr) begin
                    m_cnt[i] = 0;
                    m_ovf[i] = 0;
                end
            end
        end
    end

    // Every-cycle comparison of all three instances against the model
    always @(negedge clk) begin
        if (model_ok) begin
            chk("ov.y",   int'(y_ov), int'(m_y[0]));
            chk("ov.cnt", int'(c_ov), m_cnt[0]);
            chk("ov.ovf", int'(o_ov), int'(m_ovf[0]));
            chk("no.y",   int'(y_no), int'(m_y[1]));
            chk("no.cnt", int'(c_no), m_cnt[1]);
            chk("no.ovf", int'(o_no), int'(m_ovf[1]));
            chk("c2.y",   int'(y_c2), int'(m_y[2]));
            chk("c2.cnt", int'(c_c2), m_cnt[2]);
            chk("c2.ovf", int'(o_c2), int'(m_ovf[2]));
        end
    end

    task automatic step(input bit r, input bit v, input bit d, input bit c);
        rst = r; x_valid = v; x = d; cnt_clr = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i] == 8'h31, 1'b0);
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 0);
        chk("lit.reset.y",   int'(y_ov), 0);
        chk("lit.reset.cnt", int'(c_ov), 0);
        chk("lit.reset.ovf", int'(o_ov), 0);

        // Overlap vs non-overlap on 0,1,0,1,0
        feed("010");
        chk("lit.ov.y3",   int'(y_ov), 1);
        chk("lit.no.y3",   int'(y_no), 1);
        feed("10");
        chk("lit.ov.y5",   int'(y_ov), 1);
        chk("lit.ov.cnt5", int'(c_ov), 2);
        chk("lit.no.y5",   int'(y_no), 0);
        chk("lit.no.cnt5", int'(c_no), 1);

        // Reset mid-pattern discards the partial "01"
        feed("01");
        step(1, 1, 1, 0);
        feed("0");
        chk("lit.midrst.y",   int'(y_ov), 0);
        chk("lit.midrst.cnt", int'(c_ov), 0);
        feed("10");
        chk("lit.midrst.y2",  int'(y_ov), 1);

        // Stall cycles carrying x=1 are ignored
        step(1, 0, 0, 0);
        feed("0");
        step(0, 0, 1, 0);
        chk("lit.stall.y", int'(y_ov), 0);
        feed("1");
        step(0, 0, 1, 0);
        feed("0");
        chk("lit.qual.y",   int'(y_ov), 1);
        chk("lit.qual.cnt", int'(c_ov), 1);

        // Two-bit counter boundary: four overlapping matches
        step(1, 0, 0, 0);
        feed("0101010");
        chk("lit.c2.cnt3", int'(c_c2), 3);
        chk("lit.c2.ovf3", int'(o_c2), 0);
        feed("10");
        chk("lit.c2.y4",   int'(y_c2), 1);
        chk("lit.c2.ovf4", int'(o_c2), 1);
`ifdef SEQ_DET_SATURATE_EN
        chk("lit.c2.cnt4", int'(c_c2), 3);
`else
        chk("lit.c2.cnt4", int'(c_c2), 0);
`endif

        // Clear without a match leaves history intact
        step(0, 1, 1, 1);
        chk("lit.clr.ovf", int'(o_c2), 0);
        chk("lit.clr.cnt", int'(c_c2), 0);

        // Clear colliding with a match at count 5
        step(1, 0, 0, 0);
        feed("01010101010");
        chk("lit.col.pre", int'(c_ov), 5);
        step(0, 1, 1, 0);
        step(0, 1, 0, 1);
        chk("lit.col.y",   int'(y_ov), 1);
        chk("lit.col.cnt", int'(c_ov), 0);
        chk("lit.col.ovf", int'(o_ov), 0);
        feed("10");
        chk("lit.col.next", int'(c_ov), 1);

        step(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
